// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writers and decides decode stall / operand forwarding.
// Define HAZARD_SCOREBOARD_FORWARD_EN to enable forwarding mode; the default build stalls until writeback.
module hazard_scoreboard #(
    parameter int NREGS      = 32,
    parameter int DEPTH      = 3,
    parameter int NREAD      = 2,
    parameter int LOAD_STAGE = 1,
    localparam int W         = $clog2(NREGS),
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                advance,
    input  logic                flush,
    input  logic                id_valid,
    input  logic                id_wen,
    input  logic [W-1:0]        id_wsel,
    input  logic                id_isload,
    input  logic [NREAD*W-1:0]  id_rsel,
    output logic                stall,
    output logic [NREAD*SW-1:0] fwd_sel,
    output logic [SW-1:0]       busy_cnt
);

    typedef struct packed {
        logic         valid;
        logic [W-1:0] wsel;
        logic         isload;
    } entry_t;

    entry_t [DEPTH-1:0] stage_q, stage_d;
    logic [SW-1:0]      busy_cnt_q, busy_cnt_d;
    logic               stall_any;
    logic               insert, retire, squash;

    // Per port, scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        logic [W-1:0] rsel;
        logic         found;
        logic         found_load;
        int           found_k;
        stall_any  = 1'b0;
        fwd_sel    = '0;
        rsel       = '0;
        found      = 1'b0;
        found_load = 1'b0;
        found_k    = 0;
        for (int i = 0; i < NREAD; i++) begin
            rsel       = id_rsel[i*W +: W];
            found      = 1'b0;
            found_load = 1'b0;
            found_k    = 0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (stage_q[k].valid && stage_q[k].wsel == rsel && rsel != '0) begin
                    found      = 1'b1;
                    found_load = stage_q[k].isload;
                    found_k    = k;
                end
            end
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
            if (found && found_load && found_k < LOAD_STAGE) stall_any = 1'b1;
            if (found && found_k <= DEPTH - 2) fwd_sel[i*SW +: SW] = SW'(found_k + 1);
`else
            if (found && found_k <= DEPTH - 2) stall_any = 1'b1;
`endif
        end
    end

`ifndef HAZARD_SCOREBOARD_FORWARD_EN
    // Load tagging only matters when forwarding; kept so the entry format is build-independent.
    logic unused_isload;
    always_comb begin
        unused_isload = 1'b0;
        for (int k = 0; k < DEPTH; k++) unused_isload = unused_isload ^ stage_q[k].isload;
    end
`endif

    assign stall = id_valid & stall_any;

    assign insert = advance & id_valid & id_wen & (id_wsel != '0) & ~stall & ~flush;
    assign retire = advance & stage_q[DEPTH-1].valid;
    assign squash = flush & stage_q[0].valid;

    always_comb begin
        stage_d    = stage_q;
        busy_cnt_d = busy_cnt_q + SW'(insert) - SW'(retire) - SW'(squash);
        if (advance) begin
            for (int k = DEPTH - 1; k >= 1; k--) stage_d[k] = stage_q[k-1];
            stage_d[0].valid  = insert;
            stage_d[0].wsel   = insert ? id_wsel : '0;
            stage_d[0].isload = insert & id_isload;
            // The flushed stage-0 instruction has just moved into stage 1.
            if (flush) stage_d[1].valid = 1'b0;
        end else if (flush) begin
            stage_d[0].valid = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stage_q    <= '0;
            busy_cnt_q <= '0;
        end else begin
            stage_q    <= stage_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH=3, LOAD_STAGE=1, NREAD=2).
// Expectations adapt to whether HAZARD_SCOREBOARD_FORWARD_EN is defined.
module tb_hazard_scoreboard;

    localparam int W  = 5;
    localparam int SW = 2;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST;
    logic            advance, flush, id_valid, id_wen, id_isload;
    logic [W-1:0]    id_wsel;
    logic [2*W-1:0]  id_rsel;
    logic            stall;
    logic [2*SW-1:0] fwd_sel;
    logic [SW-1:0]   busy_cnt;

    int errors = 0;
    int checks = 0;

    logic            exp_stall;
    logic [2*SW-1:0] exp_fwd;

    hazard_scoreboard #(.NREGS(32), .DEPTH(3), .NREAD(2), .LOAD_STAGE(1)) dut (
        .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush),
        .id_valid(id_valid), .id_wen(id_wen), .id_wsel(id_wsel),
        .id_isload(id_isload), .id_rsel(id_rsel),
        .stall(stall), .fwd_sel(fwd_sel), .busy_cnt(busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        advance = 1'b0; flush = 1'b0; id_valid = 1'b0; id_wen = 1'b0;
        id_wsel = '0; id_isload = 1'b0; id_rsel = '0;
    endtask

    task automatic read(input logic [W-1:0] r0, input logic [W-1:0] r1);
        id_valid = 1'b1; id_wen = 1'b0; id_rsel = {r1, r0};
        #1;
    endtask

    task automatic insert(input logic [W-1:0] w, input logic ld);
        id_valid = 1'b1; id_wen = 1'b1; id_wsel = w; id_isload = ld;
        id_rsel = '0; advance = 1'b1; flush = 1'b0;
        tick();
        idle();
        #1;
    endtask

    task automatic drain();
        idle();
        advance = 1'b1;
        repeat (3) tick();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 2'd0) begin errors++; $display("FAIL drain_busy: got %0d want 0", busy_cnt); end
    endtask

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        #1;
        read(5'd5, 5'd0);
        tick();
        checks++;
        if (busy_cnt !== 2'd0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy_cnt); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++;
        if (fwd_sel !== 4'h0) begin errors++; $display("FAIL reset_fwd: got %0h want 0", fwd_sel); end
        #2 nRST = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_alu_writer();
        insert(5'd5, 1'b0);
        read(5'd5, 5'd0);
        exp_stall = FWD ? 1'b0 : 1'b1;
        exp_fwd   = FWD ? 4'h1 : 4'h0;
        checks++;
        if (stall !== exp_stall) begin errors++; $display("FAIL alu_s0_stall: got %0b want %0b", stall, exp_stall); end
        checks++;
        if (fwd_sel !== exp_fwd) begin errors++; $display("FAIL alu_s0_fwd: got %0h want %0h", fwd_sel, exp_fwd); end
        checks++;
        if (busy_cnt !== 2'd1) begin errors++; $display("FAIL alu_busy: got %0d want 1", busy_cnt); end
        read(5'd6, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL alu_nomatch: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        read(5'd5, 5'd0);
        advance = 1'b1;
        tick();
        exp_fwd = FWD ? 4'h2 : 4'h0;
        checks++;
        if (stall !== exp_stall) begin errors++; $display("FAIL alu_s1_stall: got %0b want %0b", stall, exp_stall); end
        checks++;
        if (fwd_sel !== exp_fwd) begin errors++; $display("FAIL alu_s1_fwd: got %0h want %0h", fwd_sel, exp_fwd); end
        tick();
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL alu_s2: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        tick();
        checks++;
        if (busy_cnt !== 2'd0) begin errors++; $display("FAIL alu_retire_busy: got %0d want 0", busy_cnt); end
        idle();
    endtask

    task automatic test_load();
        insert(5'd8, 1'b1);
        id_valid = 1'b1; id_wen = 1'b1; id_wsel = 5'd9; id_rsel = {5'd8, 5'd0}; advance = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL load_s0_stall: got %0b want 1", stall); end
        tick();
        checks++;
        if (busy_cnt !== 2'd1) begin errors++; $display("FAIL load_no_insert: got busy=%0d want 1", busy_cnt); end
        exp_stall = FWD ? 1'b0 : 1'b1;
        exp_fwd   = FWD ? 4'h8 : 4'h0;
        checks++;
        if (stall !== exp_stall) begin errors++; $display("FAIL load_s1_stall: got %0b want %0b", stall, exp_stall); end
        checks++;
        if (fwd_sel !== exp_fwd) begin errors++; $display("FAIL load_s1_fwd: got %0h want %0h", fwd_sel, exp_fwd); end
        drain();
    endtask

    task automatic test_reg_zero();
        insert(5'd0, 1'b0);
        read(5'd0, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0 || busy_cnt !== 2'd0) begin
            errors++; $display("FAIL reg0: got stall=%0b fwd=%0h busy=%0d want 0/0/0", stall, fwd_sel, busy_cnt);
        end
        idle();
        drain();
    endtask

    task automatic test_hold_and_flush();
        id_valid = 1'b1; id_wen = 1'b1; id_wsel = 5'd9; id_rsel = '0; advance = 1'b0;
        tick();
        checks++;
        if (busy_cnt !== 2'd0) begin errors++; $display("FAIL hold_no_insert: got busy=%0d want 0", busy_cnt); end
        idle();
        insert(5'd6, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        read(5'd6, 5'd0);
        checks++;
        if (busy_cnt !== 2'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL flush_hold: got busy=%0d stall=%0b want 0/0", busy_cnt, stall);
        end
        idle();
    endtask

    task automatic test_flush_advance();
        insert(5'd7, 1'b0);
        insert(5'd7, 1'b0);
        read(5'd7, 5'd0);
        exp_stall = FWD ? 1'b0 : 1'b1;
        exp_fwd   = FWD ? 4'h1 : 4'h0;
        checks++;
        if (stall !== exp_stall || fwd_sel !== exp_fwd) begin
            errors++; $display("FAIL young_s0: got stall=%0b fwd=%0h want %0b/%0h", stall, fwd_sel, exp_stall, exp_fwd);
        end
        insert(5'd3, 1'b0);
        read(5'd7, 5'd0);
        exp_fwd = FWD ? 4'h2 : 4'h0;
        checks++;
        if (stall !== exp_stall || fwd_sel !== exp_fwd) begin
            errors++; $display("FAIL young_s1: got stall=%0b fwd=%0h want %0b/%0h", stall, fwd_sel, exp_stall, exp_fwd);
        end
        checks++;
        if (busy_cnt !== 2'd3) begin errors++; $display("FAIL three_busy: got %0d want 3", busy_cnt); end
        id_valid = 1'b1; id_wen = 1'b1; id_wsel = 5'd4; id_rsel = '0; advance = 1'b1; flush = 1'b1;
        tick();
        idle();
        checks++;
        if (busy_cnt !== 2'd1) begin errors++; $display("FAIL flush_adv_busy: got %0d want 1", busy_cnt); end
        read(5'd3, 5'd4);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL flush_adv_squash: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        read(5'd7, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL flush_adv_s2: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        insert(5'd1, 1'b0);
        insert(5'd2, 1'b0);
        insert(5'd3, 1'b0);
        insert(5'd4, 1'b0);
        checks++;
        if (busy_cnt !== 2'd3) begin errors++; $display("FAIL b2b_net_zero: got %0d want 3", busy_cnt); end
        read(5'd0, 5'd2);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL b2b_s2: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        read(5'd0, 5'd3);
        exp_stall = FWD ? 1'b0 : 1'b1;
        exp_fwd   = FWD ? 4'h8 : 4'h0;
        checks++;
        if (stall !== exp_stall || fwd_sel !== exp_fwd) begin
            errors++; $display("FAIL b2b_s1: got stall=%0b fwd=%0h want %0b/%0h", stall, fwd_sel, exp_stall, exp_fwd);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        insert(5'd5, 1'b0);
        insert(5'd6, 1'b0);
        insert(5'd7, 1'b0);
        read(5'd7, 5'd0);
        exp_stall = FWD ? 1'b0 : 1'b1;
        checks++;
        if (stall !== exp_stall) begin errors++; $display("FAIL pre_reset_stall: got %0b want %0b", stall, exp_stall); end
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (busy_cnt !== 2'd0) begin errors++; $display("FAIL mid_reset_busy: got %0d want 0", busy_cnt); end
        read(5'd5, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL mid_reset_s5: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        read(5'd7, 5'd0);
        checks++;
        if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
            errors++; $display("FAIL mid_reset_s7: got stall=%0b fwd=%0h want 0/0", stall, fwd_sel);
        end
        #2 nRST = 1'b1;
        tick();
        checks++;
        if (busy_cnt !== 2'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL post_reset: got busy=%0d stall=%0b want 0/0", busy_cnt, stall);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_writer();
        test_load();
        test_reg_zero();
        test_hold_and_flush();
        test_flush_advance();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
